// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Purpose : Shared encodings for the data-memory arbiter. It defines the FSM
//           state type and the owner encoding used by dmem_arbiter and
//           dmem_arb_grant.
// Ports   : none (package)
// Config  : DMEM_ARB_RR_EN selects round-robin arbitration in dmem_arb_grant.
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

endpackage

// File: rtl/dmem_arb_grant.sv
// -----------------------------------------------------------------------------
// dmem_arb_grant
// Purpose : Picks which port gets the next memory access.
// Ports   : i_clk, i_rst, i_take  (only with DMEM_ARB_RR_EN) clock, async
//                                  reset, and "the grant is being used" strobe
//           i_cpu_req, i_dbg_req   request levels
//           o_grant_valid          at least one port is requesting
//           o_grant_owner          OWN_CPU / OWN_DBG
// Config  : DMEM_ARB_RR_EN defined   -> round-robin on ties, using a
//                                       last_owner register that resets to
//                                       debug, so the first tie goes to the CPU.
//           DMEM_ARB_RR_EN undefined -> fixed priority, CPU always wins.
// -----------------------------------------------------------------------------
module dmem_arb_grant
  import dmem_arbiter_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_take,
`endif
  input  logic i_cpu_req,
  input  logic i_dbg_req,
  output logic o_grant_valid,
  output logic o_grant_owner
);

  assign o_grant_valid = i_cpu_req | i_dbg_req;

`ifdef DMEM_ARB_RR_EN
  logic r_last_owner;

  // On a tie, the port that did not win last time gets the access.
  always_comb begin
    if (i_cpu_req && i_dbg_req) begin
      o_grant_owner = ~r_last_owner;
    end else if (i_cpu_req) begin
      o_grant_owner = OWN_CPU;
    end else begin
      o_grant_owner = OWN_DBG;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_owner <= OWN_DBG;
    end else if (i_take && o_grant_valid) begin
      r_last_owner <= o_grant_owner;
    end
  end
`else
  assign o_grant_owner = i_cpu_req ? OWN_CPU : OWN_DBG;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Purpose : Shares one single-port data memory between the CPU MEM-stage port
//           and a debug/loader port. Each access runs IDLE -> ISSUE ->
//           (WAIT for reads) -> DONE. cpu_stall holds the pipeline while a CPU
//           access is outstanding.
// Ports   : clk, rst                        clock / async active-high reset
//           cpu_req/we/byte/addr/wdata      CPU request side
//           cpu_rdata, cpu_ack, cpu_stall   CPU response side
//           dbg_req/we/addr/wdata           debug request side
//           dbg_rdata, dbg_ack              debug response side
//           mem_en/we/byte/addr/wdata       memory command (mem_en qualifies)
//           mem_rdata                       memory read data, RD_LAT after mem_en
// Config  : DMEM_ARB_RR_EN selects round-robin tie breaking (see dmem_arb_grant);
//           without it the CPU has fixed priority.
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_byte,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  if (RD_LAT < 1) begin : g_rd_lat_check
    $error("dmem_arbiter: RD_LAT must be >= 1");
  end

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_owner;
  logic                r_mem_we;
  logic                r_mem_byte;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic [DATA_W-1:0]   r_dbg_rdata;
  logic                w_grant_valid;
  logic                w_grant_owner;
  logic                w_grant;
  logic                w_last_cnt;
  logic                w_mem_en;
  logic                w_cpu_ack;
  logic                w_dbg_ack;

  dmem_arb_grant u_grant (
`ifdef DMEM_ARB_RR_EN
    .i_clk         (clk),
    .i_rst         (rst),
    .i_take        (r_state == S_IDLE),
`endif
    .i_cpu_req     (cpu_req),
    .i_dbg_req     (dbg_req),
    .o_grant_valid (w_grant_valid),
    .o_grant_owner (w_grant_owner)
  );

  // Requests are only looked at in IDLE; everywhere else they are ignored.
  assign w_grant    = (r_state == S_IDLE) && w_grant_valid;
  // mem_rdata for the ISSUE cycle shows up in the RD_LAT-th WAIT cycle.
  assign w_last_cnt = (r_cnt == CNT_W'(RD_LAT - 1));

  always_comb begin
    w_state_next = r_state;
    w_mem_en     = 1'b0;
    w_cpu_ack    = 1'b0;
    w_dbg_ack    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_valid) w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_mem_en     = 1'b1;
        w_state_next = r_mem_we ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (w_last_cnt) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_cpu_ack    = (r_owner == OWN_CPU);
        w_dbg_ack    = (r_owner == OWN_DBG);
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_owner     <= OWN_CPU;
      r_mem_we    <= 1'b0;
      r_mem_byte  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      r_state <= w_state_next;

      if (r_state == S_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_grant) begin
        r_owner <= w_grant_owner;
        if (w_grant_owner == OWN_CPU) begin
          r_mem_we    <= cpu_we;
          r_mem_byte  <= cpu_byte;
          r_mem_addr  <= cpu_addr;
          r_mem_wdata <= cpu_wdata;
        end else begin
          // The debug port only does full-word accesses.
          r_mem_we    <= dbg_we;
          r_mem_byte  <= 1'b0;
          r_mem_addr  <= dbg_addr;
          r_mem_wdata <= dbg_wdata;
        end
      end

      if ((r_state == S_WAIT) && w_last_cnt) begin
        if (r_owner == OWN_CPU) r_cpu_rdata <= mem_rdata;
        else                    r_dbg_rdata <= mem_rdata;
      end
    end
  end

  assign mem_en    = w_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_byte  = r_mem_byte;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_ack   = w_cpu_ack;
  assign dbg_ack   = w_dbg_ack;
  assign cpu_rdata = r_cpu_rdata;
  assign dbg_rdata = r_dbg_rdata;
  assign cpu_stall = cpu_req & ~w_cpu_ack;

endmodule
